// File: rtl/tp84_video_timing.sv
// -----------------------------------------------------------------------------
// tp84_video_timing
//
// Raster timing generator for the Time Pilot 84 core. Two 9-bit counters run
// in the Konami numbering scheme: the horizontal counter runs H_INIT..511 and
// the vertical counter runs V_INIT..511. Both advance only on clk edges where
// the 6 MHz pixel enable is high. Blank and sync flags are decoded from the
// *next* counter values and registered. This keeps each flag aligned with the
// h_cnt/v_cnt value presented in the same cycle.
//
// A vertical-blank interrupt latch is set at the start of vertical blank.
// The CPU's interrupt enable latch clears it and holds it off.
//
// Ports
//   clk       in   system clock (49.152 MHz)
//   reset_n   in   asynchronous active-low reset
//   cen_6m    in   pixel clock enable; all state advances only when high
//   irq_en    in   CPU interrupt enable; low clears and holds off irq_n
//   h_cnt     out  [8:0] horizontal count
//   v_cnt     out  [8:0] vertical count
//   hblank    out  horizontal blank, active high
//   vblank    out  vertical blank, active high
//   hsync_n   out  horizontal sync, active low
//   vsync_n   out  vertical sync, active low
//   irq_n     out  vertical blank interrupt, active low level
//   field     out  toggles once per frame
// -----------------------------------------------------------------------------
module tp84_video_timing #(
   parameter logic [8:0] H_INIT    = 9'd128,
   parameter logic [8:0] V_INIT    = 9'd248,
   parameter logic [8:0] HBL_END   = 9'd144,
   parameter logic [8:0] HBL_START = 9'd400,
   parameter logic [8:0] HS_START  = 9'd432,
   parameter logic [8:0] HS_END    = 9'd464,
   parameter logic [8:0] VBL_END   = 9'd272,
   parameter logic [8:0] VBL_START = 9'd496,
   parameter logic [8:0] VS_START  = 9'd248,
   parameter logic [8:0] VS_END    = 9'd256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cen_6m,
   input  logic       irq_en,
   output logic [8:0] h_cnt,
   output logic [8:0] v_cnt,
   output logic       hblank,
   output logic       vblank,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       irq_n,
   output logic       field
);

   localparam logic [8:0] CNT_MAX = 9'd511;

   // ---------------------------------------------------------------------
   // Decode helpers. They are shared by the run-time decode and the reset
   // values, so the reset state is always the decode of (H_INIT, V_INIT).
   // ---------------------------------------------------------------------
   function automatic logic in_window(input logic [8:0] x,
                                      input logic [8:0] lo,
                                      input logic [8:0] hi);
      return (x >= lo) && (x < hi);
   endfunction

   function automatic logic hblank_dec(input logic [8:0] h);
      return (h < HBL_END) || (h >= HBL_START);
   endfunction

   function automatic logic vblank_dec(input logic [8:0] v);
      return (v < VBL_END) || (v >= VBL_START);
   endfunction

   function automatic logic hsync_n_dec(input logic [8:0] h);
      return ~in_window(h, HS_START, HS_END);
   endfunction

   function automatic logic vsync_n_dec(input logic [8:0] v);
      return ~in_window(v, VS_START, VS_END);
   endfunction

   logic       h_wrap_s;
   logic       v_wrap_s;
   logic [8:0] h_nxt_s;
   logic [8:0] v_nxt_s;
   logic       frame_wrap_s;
   logic       irq_set_s;

   // Next-count computation, frame-wrap detect and interrupt set condition.
   always_comb begin
      h_wrap_s     = 1'b0;
      v_wrap_s     = 1'b0;
      h_nxt_s      = h_cnt;
      v_nxt_s      = v_cnt;
      frame_wrap_s = 1'b0;
      irq_set_s    = 1'b0;

      h_wrap_s = (h_cnt == CNT_MAX);
      v_wrap_s = (v_cnt == CNT_MAX);

      if (h_wrap_s) begin
         h_nxt_s = H_INIT;
      end else begin
         h_nxt_s = h_cnt + 9'd1;
      end

      // The vertical counter only moves on the horizontal wrap edge.
      if (h_wrap_s) begin
         if (v_wrap_s) begin
            v_nxt_s = V_INIT;
         end else begin
            v_nxt_s = v_cnt + 9'd1;
         end
      end else begin
         v_nxt_s = v_cnt;
      end

      frame_wrap_s = h_wrap_s && v_wrap_s;

      // Set on the enabled edge whose new counts are (H_INIT, VBL_START).
      irq_set_s = cen_6m && h_wrap_s && (h_nxt_s == H_INIT) && (v_nxt_s == VBL_START);
   end

   // Counter, field and registered blank/sync decode state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt   <= H_INIT;
         v_cnt   <= V_INIT;
         field   <= 1'b0;
         hblank  <= hblank_dec(H_INIT);
         vblank  <= vblank_dec(V_INIT);
         hsync_n <= hsync_n_dec(H_INIT);
         vsync_n <= vsync_n_dec(V_INIT);
      end else if (cen_6m) begin
         h_cnt   <= h_nxt_s;
         v_cnt   <= v_nxt_s;
         field   <= field ^ frame_wrap_s;
         hblank  <= hblank_dec(h_nxt_s);
         vblank  <= vblank_dec(v_nxt_s);
         hsync_n <= hsync_n_dec(h_nxt_s);
         vsync_n <= vsync_n_dec(v_nxt_s);
      end else begin
         h_cnt   <= h_cnt;
         v_cnt   <= v_cnt;
         field   <= field;
         hblank  <= hblank;
         vblank  <= vblank;
         hsync_n <= hsync_n;
         vsync_n <= vsync_n;
      end
   end

   // Vertical-blank interrupt latch. The clear from irq_en low is checked
   // every clk, ignoring cen_6m, and it takes priority over a coincident set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_n <= 1'b1;
      end else if (!irq_en) begin
         irq_n <= 1'b1;
      end else if (irq_set_s) begin
         irq_n <= 1'b0;
      end else begin
         irq_n <= irq_n;
      end
   end

endmodule

// File: tb/tb_tp84_video_timing.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tp84_video_timing.
//
// The DUT is built with a shortened raster of 64 pixels by 32 lines, so whole
// frames fit in a short run. The ordering of every window inside the line and
// the frame is the same as in the full-size timing.
//
// The reference model tracks the number of enabled edges since reset. It
// derives the expected counts, flags, field and IRQ state from that number
// with plain arithmetic. A hand-computed vector table is also checked.
// -----------------------------------------------------------------------------
module tb_tp84_video_timing;

   localparam int H_INIT    = 448;
   localparam int V_INIT    = 480;
   localparam int HBL_END   = 456;
   localparam int HBL_START = 496;
   localparam int HS_START  = 500;
   localparam int HS_END    = 504;
   localparam int VBL_END   = 484;
   localparam int VBL_START = 508;
   localparam int VS_START  = 480;
   localparam int VS_END    = 482;
   localparam int LINE      = 512 - H_INIT;
   localparam int LINES     = 512 - V_INIT;
   localparam int FRAME     = LINE * LINES;

   logic       clk;
   logic       reset_n;
   logic       cen_6m;
   logic       irq_en;
   logic [8:0] h_cnt;
   logic [8:0] v_cnt;
   logic       hblank;
   logic       vblank;
   logic       hsync_n;
   logic       vsync_n;
   logic       irq_n;
   logic       field;

   tp84_video_timing #(
      .H_INIT   (9'(H_INIT)),
      .V_INIT   (9'(V_INIT)),
      .HBL_END  (9'(HBL_END)),
      .HBL_START(9'(HBL_START)),
      .HS_START (9'(HS_START)),
      .HS_END   (9'(HS_END)),
      .VBL_END  (9'(VBL_END)),
      .VBL_START(9'(VBL_START)),
      .VS_START (9'(VS_START)),
      .VS_END   (9'(VS_END))
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .cen_6m (cen_6m),
      .irq_en (irq_en),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .hblank (hblank),
      .vblank (vblank),
      .hsync_n(hsync_n),
      .vsync_n(vsync_n),
      .irq_n  (irq_n),
      .field  (field)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: enabled edges since reset, and the IRQ level.
   int   ticks = 0;
   logic m_irq = 1'b1;

   function automatic int m_h(input int t);
      return H_INIT + (t % LINE);
   endfunction

   function automatic int m_v(input int t);
      return V_INIT + ((t / LINE) % LINES);
   endfunction

   function automatic int m_field(input int t);
      return (t / FRAME) % 2;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0d: got %0d, expected %0d", nm, ticks, act, exp);
      end
   endtask

   task automatic check_all();
      int h;
      int v;
      h = m_h(ticks);
      v = m_v(ticks);
      chk("h_cnt",   int'(h_cnt),   h);
      chk("v_cnt",   int'(v_cnt),   v);
      chk("hblank",  int'(hblank),  ((h < HBL_END) || (h >= HBL_START)) ? 1 : 0);
      chk("vblank",  int'(vblank),  ((v < VBL_END) || (v >= VBL_START)) ? 1 : 0);
      chk("hsync_n", int'(hsync_n), ((h >= HS_START) && (h < HS_END)) ? 0 : 1);
      chk("vsync_n", int'(vsync_n), ((v >= VS_START) && (v < VS_END)) ? 0 : 1);
      chk("irq_n",   int'(irq_n),   int'(m_irq));
      chk("field",   int'(field),   m_field(ticks));
   endtask

   // One clk: drive inputs, advance the model at the edge, check at negedge.
   task automatic step(input logic c, input logic e);
      cen_6m = c;
      irq_en = e;
      @(posedge clk);
      if (c) ticks++;
      if (!e) begin
         m_irq = 1'b1;
      end else if (c && (m_h(ticks) == H_INIT) && (m_v(ticks) == VBL_START)) begin
         m_irq = 1'b0;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic run_to(input int target, input logic e);
      while (ticks < target) step(1'b1, e);
   endtask

   typedef struct {
      int   adv;
      int   h;
      int   v;
      logic hb;
      logic vb;
      logic hs_n;
      logic vs_n;
      logic irq;
      logic fld;
   } vec_t;

   vec_t tbl[13];

   initial begin
      // Hand-computed raster points; adv = enabled edges since the previous row.
      tbl[0]  = '{0,    448, 480, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1,    449, 480, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{7,    456, 480, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{40,   496, 480, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{4,    500, 480, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{3,    503, 480, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1,    504, 480, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{8,    448, 481, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{64,   448, 482, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{128,  448, 484, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{8,    456, 484, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1528, 448, 508, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{256,  448, 480, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset with the enable toggling: nothing may move.
      reset_n = 1'b0;
      cen_6m  = 1'b0;
      irq_en  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cen_6m = ~cen_6m;
      end
      check_all();
      reset_n = 1'b1;

      // Vector table: line and frame sweep with the IRQ enabled.
      for (int i = 0; i < 13; i++) begin
         for (int k = 0; k < tbl[i].adv; k++) step(1'b1, 1'b1);
         chk("tbl_h",    int'(h_cnt),   tbl[i].h);
         chk("tbl_v",    int'(v_cnt),   tbl[i].v);
         chk("tbl_hbl",  int'(hblank),  int'(tbl[i].hb));
         chk("tbl_vbl",  int'(vblank),  int'(tbl[i].vb));
         chk("tbl_hs",   int'(hsync_n), int'(tbl[i].hs_n));
         chk("tbl_vs",   int'(vsync_n), int'(tbl[i].vs_n));
         chk("tbl_irq",  int'(irq_n),   int'(tbl[i].irq));
         chk("tbl_fld",  int'(field),   int'(tbl[i].fld));
      end

      // Drop irq_en for one clk with no pixel enable: the clear must still land.
      step(1'b0, 1'b0);
      chk("irq_clear", int'(irq_n), 1);
      // Raising it again must not re-arm until the next frame's set point.
      run_to(FRAME + (VBL_START - V_INIT) * LINE - 1, 1'b1);
      chk("irq_no_retro", int'(irq_n), 1);
      step(1'b1, 1'b1);
      chk("irq_reset2", int'(irq_n), 0);

      // Asynchronous reset mid-frame while the IRQ is pending.
      run_to(ticks + 100, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      ticks = 0;
      m_irq = 1'b1;
      check_all();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cen_6m = ~cen_6m;
      end
      check_all();
      reset_n = 1'b1;
      step(1'b1, 1'b1);
      chk("post_rst_h", int'(h_cnt), 449);
      chk("post_rst_v", int'(v_cnt), 480);

      // irq_en falling on the exact set edge: the clear wins.
      run_to((VBL_START - V_INIT) * LINE - 1, 1'b1);
      step(1'b1, 1'b0);
      chk("irq_clear_wins", int'(irq_n), 1);

      // irq_en held low across the next frame's set point.
      run_to(FRAME + (VBL_START - V_INIT) * LINE + 8, 1'b0);
      chk("irq_held_off", int'(irq_n), 1);

      // Pixel enable on every 8th clk only.
      for (int i = 0; i < 800; i++) step((i % 8) == 0, 1'b1);

      // Randomised enables and interrupt-enable pulses.
      for (int i = 0; i < 6000; i++) begin
         step(($urandom % 4) != 0, ($urandom % 64) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
